// File: rtl/ofdm_rx_byte_packer.sv
// Packs demodulated OFDM bit pairs into frame-aligned words and buffers them
// in a first-word-fall-through FIFO with valid/ready output and error flags.
module ofdm_rx_byte_packer #(
  parameter int DATA_WIDTH_G      = 8,
  parameter int PAIRS_PER_FRAME_G = 64,
  parameter int FIFO_DEPTH_G      = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rstn,
  input  logic                          sys_init,
  input  logic [1:0]                    rx_rcv_data,
  input  logic                          rx_rcv_data_valid,
  input  logic                          rx_rcv_data_start,
  output logic [DATA_WIDTH_G-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_first,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH_G):0] fifo_level,
  output logic                          overflow,
  output logic                          frame_error
);

  localparam int PPW     = DATA_WIDTH_G / 2;
  localparam int PAIR_W  = $clog2(PPW + 1);
  localparam int FRAME_W = $clog2(PAIRS_PER_FRAME_G + 1);
  localparam int ADDR_W  = $clog2(FIFO_DEPTH_G);
  localparam int LVL_W   = ADDR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH_G + 2;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t                    state_r;
  logic [DATA_WIDTH_G-1:0]   word_r;
  logic [PAIR_W-1:0]         pair_cnt_r;
  logic [FRAME_W-1:0]        frame_cnt_r;
  logic                      first_r;
  logic                      frame_error_r;

  logic                      start_s;
  logic                      accept_s;
  logic [PAIR_W-1:0]         pair_idx_s;
  logic                      first_s;
  logic [FRAME_W-1:0]        frame_cnt_nxt_s;
  logic [DATA_WIDTH_G-1:0]   base_s;
  logic [DATA_WIDTH_G-1:0]   word_s;
  logic                      complete_s;
  logic                      last_s;

  logic [ENTRY_W-1:0]        mem_r [FIFO_DEPTH_G];
  logic [ADDR_W-1:0]         wr_ptr_r;
  logic [ADDR_W-1:0]         rd_ptr_r;
  logic [LVL_W-1:0]          level_r;
  logic [DATA_WIDTH_G-1:0]   out_data_r;
  logic                      out_valid_r;
  logic                      out_first_r;
  logic                      out_last_r;
  logic                      overflow_r;

  logic                      pop_s;
  logic                      full_s;
  logic                      wr_en_s;
  logic [ADDR_W-1:0]         rd_ptr_nxt_s;
  logic [LVL_W-1:0]          stored_s;
  logic [ENTRY_W-1:0]        head_s;

  // Next-word assembly: a start pair always opens a fresh word at pair 0.
  always_comb begin
    start_s         = rx_rcv_data_valid && rx_rcv_data_start;
    accept_s        = rx_rcv_data_valid && (rx_rcv_data_start || (state_r == ST_COLLECT));
    pair_idx_s      = start_s ? '0 : pair_cnt_r;
    first_s         = start_s ? 1'b1 : first_r;
    frame_cnt_nxt_s = start_s ? FRAME_W'(1) : (frame_cnt_r + FRAME_W'(1));
    base_s          = start_s ? '0 : word_r;
    word_s          = base_s;
    for (int k = 0; k < PPW; k++) begin
      word_s[2*k +: 2] = (pair_idx_s == PAIR_W'(k)) ? rx_rcv_data : base_s[2*k +: 2];
    end
    complete_s      = accept_s && (pair_idx_s == PAIR_W'(PPW - 1));
    last_s          = (frame_cnt_nxt_s == FRAME_W'(PAIRS_PER_FRAME_G));
  end

  // Packer state machine and sticky framing flag.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_r       <= ST_IDLE;
      word_r        <= '0;
      pair_cnt_r    <= '0;
      frame_cnt_r   <= '0;
      first_r       <= 1'b0;
      frame_error_r <= 1'b0;
    end else if (sys_init) begin
      state_r       <= ST_IDLE;
      word_r        <= '0;
      pair_cnt_r    <= '0;
      frame_cnt_r   <= '0;
      first_r       <= 1'b0;
      frame_error_r <= 1'b0;
    end else begin
      if (accept_s) begin
        frame_cnt_r <= frame_cnt_nxt_s;
        if (complete_s) begin
          word_r     <= '0;
          pair_cnt_r <= '0;
          first_r    <= 1'b0;
          state_r    <= last_s ? ST_IDLE : ST_COLLECT;
        end else begin
          word_r     <= word_s;
          pair_cnt_r <= pair_idx_s + PAIR_W'(1);
          first_r    <= first_s;
          state_r    <= ST_COLLECT;
        end
      end
      if (start_s && (state_r == ST_COLLECT)) begin
        frame_error_r <= 1'b1;
      end
    end
  end

  // Output stage only sees entries written on earlier edges, so no bypass is needed.
  always_comb begin
    pop_s        = out_valid_r && out_ready;
    full_s       = (level_r == LVL_W'(FIFO_DEPTH_G));
    wr_en_s      = complete_s && (!full_s || pop_s);
    rd_ptr_nxt_s = rd_ptr_r + ADDR_W'(pop_s);
    stored_s     = level_r - LVL_W'(pop_s);
    head_s       = mem_r[rd_ptr_nxt_s];
  end

  // FIFO storage array.
  always_ff @(posedge sys_clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {word_s, first_s, last_s};
    end
  end

  // FIFO pointers, level, registered head and overflow flag.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      level_r     <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_first_r <= 1'b0;
      out_last_r  <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (sys_init) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      level_r     <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_first_r <= 1'b0;
      out_last_r  <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_en_s ? (wr_ptr_r + ADDR_W'(1)) : wr_ptr_r;
      rd_ptr_r    <= rd_ptr_nxt_s;
      level_r     <= level_r + LVL_W'(wr_en_s) - LVL_W'(pop_s);
      out_valid_r <= (stored_s != '0);
      if (stored_s != '0) begin
        {out_data_r, out_first_r, out_last_r} <= head_s;
      end else begin
        {out_data_r, out_first_r, out_last_r} <= '0;
      end
      if (complete_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign out_first   = out_first_r;
  assign out_last    = out_last_r;
  assign fifo_level  = level_r;
  assign overflow    = overflow_r;
  assign frame_error = frame_error_r;

endmodule

// File: tb/tb_ofdm_rx_byte_packer.sv
// Scoreboard bench for ofdm_rx_byte_packer: a frame-level reference model fills
// an expected-word queue, a negedge monitor drains it on every handshake.
module tb_ofdm_rx_byte_packer;

  localparam int DW    = 8;
  localparam int PPF   = 64;
  localparam int DEPTH = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rstn = 1'b0;
  logic          sys_init = 1'b0;
  logic [1:0]    rx_rcv_data = 2'b00;
  logic          rx_rcv_data_valid = 1'b0;
  logic          rx_rcv_data_start = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_first;
  logic          out_last;
  logic [4:0]    fifo_level;
  logic          overflow;
  logic          frame_error;

  ofdm_rx_byte_packer #(
    .DATA_WIDTH_G(DW), .PAIRS_PER_FRAME_G(PPF), .FIFO_DEPTH_G(DEPTH)
  ) dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn), .sys_init(sys_init),
    .rx_rcv_data(rx_rcv_data), .rx_rcv_data_valid(rx_rcv_data_valid),
    .rx_rcv_data_start(rx_rcv_data_start),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last), .fifo_level(fifo_level),
    .overflow(overflow), .frame_error(frame_error)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          f;
    logic          l;
  } ent_t;

  int total = 0;
  int bad   = 0;

  ent_t       exp_q[$];
  logic [1:0] cur[$];
  int         occ = 0;
  int         fcnt = 0;
  bit         in_frame = 1'b0;
  bit         firstw = 1'b0;
  bit         mvalid = 1'b0;
  bit         exp_ovf = 1'b0;
  bit         exp_ferr = 1'b0;
  bit         pop_flag = 1'b0;
  bit         mdl_push;
  ent_t       mdl_e;

  bit            stall_prev = 1'b0;
  logic [DW-1:0] held_data = '0;
  int            n_pop = 0;
  int            n_last = 0;
  logic [DW-1:0] first_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frames of PPF pairs, words of DW/2 pairs, FIFO of DEPTH words.
  always @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn || sys_init) begin
      exp_q.delete(); cur.delete();
      occ = 0; fcnt = 0; in_frame = 0; firstw = 0;
      mvalid = 0; exp_ovf = 0; exp_ferr = 0;
    end else begin
      mdl_push = 0;
      if (rx_rcv_data_valid) begin
        if (rx_rcv_data_start) begin
          if (in_frame) exp_ferr = 1;
          in_frame = 1; cur.delete(); fcnt = 0; firstw = 1;
        end
        if (in_frame) begin
          cur.push_back(rx_rcv_data);
          fcnt++;
          if (cur.size() == DW / 2) begin
            mdl_e.d = '0;
            foreach (cur[k]) mdl_e.d[2*k +: 2] = cur[k];
            mdl_e.f = firstw;
            mdl_e.l = (fcnt == PPF);
            mdl_push = 1;
            cur.delete();
            firstw = 0;
            if (mdl_e.l) in_frame = 0;
          end
        end
      end
      mvalid = (occ - (pop_flag ? 1 : 0)) > 0;
      if (mdl_push) begin
        if (occ < DEPTH || pop_flag) begin
          exp_q.push_back(mdl_e);
          occ++;
        end else begin
          exp_ovf = 1;
        end
      end
      if (pop_flag) occ--;
    end
  end

  // Monitor: status compare every cycle, word compare on each handshake.
  always @(negedge sys_clk) begin
    ent_t e;
    pop_flag = out_valid && out_ready;
    chk("fifo_level", fifo_level, occ);
    chk("out_valid", out_valid, mvalid);
    chk("overflow", overflow, exp_ovf);
    chk("frame_error", frame_error, exp_ferr);
    if (stall_prev && out_valid) chk("hold_data", out_data, held_data);
    stall_prev = out_valid && !out_ready;
    held_data  = out_data;
    if (pop_flag) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_word", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", out_data, e.d);
        chk("word_first", out_first, e.f);
        chk("word_last", out_last, e.l);
        n_pop++;
        if (out_last) n_last++;
        if (out_first) first_data = out_data;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic pair(input logic [1:0] d, input logic s);
    rx_rcv_data = d; rx_rcv_data_start = s; rx_rcv_data_valid = 1'b1;
    @(posedge sys_clk); #1;
    rx_rcv_data_valid = 1'b0; rx_rcv_data_start = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    pair(2'($urandom), 1'b1);
    for (int i = 1; i < PPF; i++) begin
      idle(gap);
      pair(2'($urandom), 1'b0);
    end
  endtask

  task automatic init_pulse();
    sys_init = 1'b1;
    @(posedge sys_clk); #1;
    sys_init = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (fifo_level == 0 && !out_valid) break;
      @(posedge sys_clk); #1;
    end
    chk("drain_level", fifo_level, 0);
    idle(2);
  endtask

  initial begin
    int base;
    idle(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_first_last", {out_first, out_last}, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_flags", {overflow, frame_error}, 0);
    sys_rstn = 1'b1;
    idle(2);

    // One frame with known leading pairs.
    out_ready = 1'b1;
    base = n_pop;
    pair(2'b01, 1'b1); pair(2'b10, 1'b0); pair(2'b11, 1'b0); pair(2'b00, 1'b0);
    for (int i = 0; i < 60; i++) pair(2'($urandom), 1'b0);
    drain();
    chk("frame_words", n_pop - base, 16);
    chk("frame_first_word", first_data, 8'h39);
    chk("frame_last_count", n_last, 1);

    // Spaced pairs: orphan pairs dropped, then latency of the first word.
    for (int i = 0; i < 5; i++) begin idle(23); pair(2'($urandom), 1'b0); end
    idle(3);
    chk("orphan_valid", out_valid, 0);
    chk("orphan_level", fifo_level, 0);
    pair(2'($urandom), 1'b1);
    for (int i = 1; i < 4; i++) begin idle(23); pair(2'($urandom), 1'b0); end
    chk("lat_edge_n", out_valid, 0);
    idle(1);
    chk("lat_edge_n1", out_valid, 1);
    for (int i = 4; i < PPF; i++) begin idle(23); pair(2'($urandom), 1'b0); end
    drain();

    // Back-pressure: 17 words into a 16-deep FIFO.
    init_pulse();
    out_ready = 1'b0;
    base = n_pop;
    send_frame(0);
    pair(2'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) pair(2'($urandom), 1'b0);
    idle(4);
    chk("bp_level", fifo_level, 16);
    chk("bp_overflow", overflow, 1);
    drain();
    chk("bp_words", n_pop - base, 16);

    // Full FIFO with a push and a pop on the same edge.
    init_pulse();
    out_ready = 1'b0;
    send_frame(0);
    idle(2);
    pair(2'($urandom), 1'b1);
    pair(2'($urandom), 1'b0);
    pair(2'($urandom), 1'b0);
    out_ready = 1'b1;
    pair(2'($urandom), 1'b0);
    out_ready = 1'b0;
    chk("fullpop_level", fifo_level, 16);
    chk("fullpop_overflow", overflow, 0);
    drain();

    // Start arriving mid-word.
    init_pulse();
    out_ready = 1'b1;
    base = n_pop;
    pair(2'($urandom), 1'b1);
    pair(2'($urandom), 1'b0);
    pair(2'($urandom), 1'b0);
    send_frame(0);
    chk("midword_ferr", frame_error, 1);
    drain();
    chk("midword_words", n_pop - base, 16);

    // sys_init with buffered words and a pending pair.
    out_ready = 1'b0;
    pair(2'($urandom), 1'b1);
    for (int i = 0; i < 20; i++) pair(2'($urandom), 1'b0);
    idle(2);
    chk("init_pre_level", fifo_level, 5);
    init_pulse();
    chk("init_level", fifo_level, 0);
    chk("init_valid", out_valid, 0);
    chk("init_flags", {overflow, frame_error}, 0);
    out_ready = 1'b1;
    base = n_pop;
    send_frame(1);
    drain();
    chk("init_after_words", n_pop - base, 16);

    // Asynchronous reset mid-frame and mid-stall.
    out_ready = 1'b0;
    pair(2'($urandom), 1'b1);
    for (int i = 0; i < 9; i++) pair(2'($urandom), 1'b0);
    idle(2);
    #3 sys_rstn = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_level", fifo_level, 0);
    @(posedge sys_clk); #1;
    sys_rstn = 1'b1;
    out_ready = 1'b1;
    base = n_pop;
    send_frame(0);
    drain();
    chk("arst_after_words", n_pop - base, 16);

    // Random traffic with occasional restarts and stalls.
    init_pulse();
    for (int i = 0; i < 1500; i++) begin
      rx_rcv_data       = 2'($urandom);
      rx_rcv_data_valid = ($urandom_range(0, 1) == 1);
      rx_rcv_data_start = ($urandom_range(0, 39) == 0);
      out_ready         = ($urandom_range(0, 3) != 0);
      @(posedge sys_clk); #1;
    end
    rx_rcv_data_valid = 1'b0;
    rx_rcv_data_start = 1'b0;
    drain();
    chk("sb_leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ofdm_rx_byte_packer.md
Name: ofdm_rx_byte_packer

Overview:
Sink stage directly downstream of the OFDM RX top level. Collects the 2-bit demodulated pairs (rx_rcv_data / rx_rcv_data_valid / rx_rcv_data_start) into DATA_WIDTH_G-bit words, frame-aligned on the start marker. Buffers the words in a first-word-fall-through FIFO with a valid/ready output. Also reports framing and overflow errors to the system controller.

Parameters:
DATA_WIDTH_G, 8, output word width; even, at least 2
PAIRS_PER_FRAME_G, 64, bit pairs per received frame; multiple of DATA_WIDTH_G/2
FIFO_DEPTH_G, 16, output FIFO depth in words; power of 2, at least 2

Ports:
sys_clk  in  1  system clock
sys_rstn  in  1  asynchronous active-low reset
sys_init  in  1  synchronous clear, one-cycle pulse; same effect as reset
rx_rcv_data  in  2  demodulated bit pair; bit 0 is the earlier bit
rx_rcv_data_valid  in  1  pair valid; every high cycle is one pair
rx_rcv_data_start  in  1  qualifies the first pair of a frame; ignored unless valid=1
out_data  out  DATA_WIDTH_G  packed word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data when out_valid and out_ready are both 1
out_first  out  1  word is first of a frame
out_last  out  1  word is last of a frame
fifo_level  out  clog2(FIFO_DEPTH_G)+1  words held
overflow  out  1  sticky: a completed word was dropped
frame_error  out  1  sticky: start arrived inside a frame

Behaviour:
- Reset or sys_init: all outputs 0; FIFO emptied; packer to IDLE; sticky flags cleared. sys_init wins over all same-cycle inputs.
- Packing: pair k of a word goes to bits [2k+1:2k] (LSB-first). A word is complete after DATA_WIDTH_G/2 pairs.
- Packer FSM:
  - IDLE: valid without start → pair dropped, no flag. Valid with start → pair 0 stored, first-flag set, pair_cnt=1, frame_cnt=1, go to COLLECT.
  - COLLECT, valid without start: store pair; pair_cnt++ and frame_cnt++.
    - Word completes → push {word, first, last}; first clears after the push.
    - last=1 iff frame_cnt reaches PAIRS_PER_FRAME_G. On that push, return to IDLE.
  - COLLECT, valid with start: discard the partial word (a complete word is never discarded), set frame_error, restart as in IDLE+start. Words of the aborted frame already pushed stay in the FIFO; the aborted frame never gets an out_last word.
- Latency: the push happens on the clock edge that samples the completing pair. out_valid is high on the following cycle when the FIFO was empty (pair valid at edge N → out_valid after edge N+1).
- FIFO:
  - First-word-fall-through. out_data, out_first and out_last are registered from the head entry. Pop occurs on out_valid & out_ready.
  - Push when full: word dropped, overflow set, fifo_level unchanged — unless a pop occurs the same cycle, in which case the push is accepted and the level stays FIFO_DEPTH_G.
  - Simultaneous push/pop on a non-empty FIFO: level unchanged.
  - Push/pop on an empty FIFO: no pop; level becomes 1.
  - Read and write pointers wrap modulo FIFO_DEPTH_G.
- out_data is held stable while out_valid=1 and out_ready=0.
- Asynchronous reset mid-frame or mid-handshake: everything is cleared immediately; no partial word survives.

Test Plan:
- One frame, defaults: start + pairs 2'b01,2'b10,2'b11,2'b00, then 60 further pairs, out_ready=1 → 16 words, first word 8'h39, out_first on word 0 only, out_last on word 15 only, no error flags.
- Pair spacing: pairs strobed every 24 clocks, completing pair at edge N → out_valid first high after edge N+1; pairs before any start are dropped, out_valid stays 0.
- Back-pressure: out_ready=0 over 17 complete words with FIFO_DEPTH_G=16 → fifo_level=16, overflow=1, the 17th word is lost; release out_ready → words 0–15 emerge in order, out_data stable while stalled.
- Full with simultaneous pop: FIFO at 16, push and pop on the same edge → push accepted, level stays 16, overflow stays 0.
- Start mid-word: start, 2 pairs, start again → frame_error=1, partial word never output, new frame packs correctly from the second start.
- sys_init pulse while 5 words are buffered and 1 pair is pending → next cycle fifo_level=0, out_valid=0, flags 0; a following frame is delivered intact.
